// File: rtl/mult_div_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Imported by mult_div_unit and md_step.
package mult_div_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinish
    } state_e;

    // Counter must hold 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of the shift-add multiply or restoring divide datapath.
// Purely combinational; the caller registers acc/rem.
module md_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH:0]     rem_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [WIDTH:0]     rem_o
);

    logic [WIDTH-1:0] add_val;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        add_val = acc_i[0] ? opnd_i : '0;
        sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, add_val};
        rem_sh  = {rem_i[WIDTH-1:0], acc_i[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, opnd_i};
        acc_o   = acc_i;
        rem_o   = rem_i;
        if (is_div_i) begin
            // Low half shifts the dividend out and the quotient bits in.
            acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], ~diff[WIDTH+1]};
            rem_o = diff[WIDTH+1] ? rem_sh : diff[WIDTH:0];
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Holds the FSM, iteration counter, sign bookkeeping and HI/LO; md_step does one iteration.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH:0]     step_rem;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo_neg, rem_neg;

    md_step #(
        .WIDTH (WIDTH)
    ) u_md_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .rem_i    (rem_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .rem_o    (step_rem)
    );

    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;
        prod_neg  = -acc_q;
        quo_neg   = -acc_q[WIDTH-1:0];
        rem_neg   = -rem_q[WIDTH-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    is_div_d   = op[1];
                    neg_res_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d  = is_signed && a[WIDTH-1];
                    cnt_d      = '0;
                    rem_d      = '0;
                    div_zero_d = 1'b0;
                    dz_d       = op[1] && (b == '0);
                    // Divide: low half holds the dividend; multiply: the multiplier.
                    if (op[1]) begin
                        opnd_d = mag_b;
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                    end
                    state_d = (op[1] && (b == '0)) ? StFinish : StRun;
                end else begin
                    if (hi_wr) hi_d = wdata;
                    if (lo_wr) lo_d = wdata;
                end
            end
            StRun: begin
                acc_d = step_acc;
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = StFinish;
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (dz_q) begin
                    div_zero_d = 1'b1;
                end else if (is_div_q) begin
                    lo_d = neg_res_q ? quo_neg : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? rem_neg : rem_q[WIDTH-1:0];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed operations push expected HI/LO/div_zero,
// a monitor compares on every done pulse.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mult_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("div_zero", 64'(div_zero), 64'(e.dz));
                chk("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    // Called just after a negedge; returns just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz);
        exp_t e;
        e.hi = eh;
        e.lo = el;
        e.dz = edz;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge where done is high; exp_lat < 0 skips the latency check.
    task automatic wait_done(input string name, input int exp_lat, output int busy_cyc);
        int  lat;
        bit  seen;
        lat      = 0;
        seen     = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            chk({name, "_timeout"}, 64'(0), 64'(1));
            sb.delete();
        end else if (exp_lat >= 0) begin
            chk({name, "_latency"}, 64'(lat - 1), 64'(exp_lat));
        end
    endtask

    int bc;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_done("mult_neg", 33, bc);

        // Back-to-back: issued in the same cycle done is high.
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done("multu_max", 33, bc);
        chk("multu_busy_cycles", 64'(bc), 64'(33));

        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done("div_neg_dividend", 33, bc);

        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        wait_done("div_neg_divisor", 33, bc);

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        wait_done("div_overflow", 33, bc);

        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done("divu", 33, bc);

        @(negedge clk);
        hi_wr = 1'b1;
        lo_wr = 1'b1;
        wdata = 32'h33;
        @(negedge clk);
        chk("both_wr_hi", 64'(hi), 64'h33);
        chk("both_wr_lo", 64'(lo), 64'h33);
        lo_wr = 1'b0;
        wdata = 32'h11;
        @(negedge clk);
        hi_wr = 1'b0;
        lo_wr = 1'b1;
        wdata = 32'h22;
        @(negedge clk);
        lo_wr = 1'b0;
        chk("mthi", 64'(hi), 64'h11);
        chk("mtlo", 64'(lo), 64'h22);

        issue(2'b11, 32'd100, 32'd0, 32'h11, 32'h22, 1'b1);
        wait_done("divu_zero", 1, bc);
        chk("div0_busy_cycles", 64'(bc), 64'(1));
        repeat (3) @(negedge clk);
        chk("div0_sticky", 64'(div_zero), 64'(1));

        issue(2'b00, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        chk("dz_cleared_on_start", 64'(div_zero), 64'(0));
        wait_done("mult_after_dz", 33, bc);

        // Abort mid-operation with reset.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd1234;
        b     = 32'd5678;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_dz", 64'(div_zero), 64'(0));
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", 64'(busy), 64'(0));
        chk("abort_lo_held", 64'(lo), 64'(0));

        // Requests during busy must be ignored.
        issue(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd9;
        b     = 32'd0;
        hi_wr = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        hi_wr = 1'b0;
        wait_done("ignored_reqs", -1, bc);
        repeat (40) @(negedge clk);
        chk("ignored_no_restart", 64'(busy), 64'(0));
        chk("ignored_hi", 64'(hi), 64'(0));

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers for the multicycle CPU datapath. It replaces the fixed single-register multiply/divide holding stage: it executes MULT, MULTU, DIV and DIVU over a start/done handshake and holds results in HI/LO for MFHI/MFLO. It sits beside the ALU. Operands come from the A/B registers, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits; must be ≥ 4.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request an operation; accepted only when `busy`=0.
- `op`  in  2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with `start`.
- `a`, `b`  in  WIDTH: multiplicand/dividend and multiplier/divisor; sampled with `start`.
- `hi_wr`, `lo_wr`  in  1: MTHI/MTLO write strobes.
- `wdata`  in  WIDTH: data for `hi_wr`/`lo_wr`.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse when HI/LO have been updated (or a divide-by-zero has been flagged).
- `div_zero`  out  1: last accepted divide had `b`=0; sticky until the next accepted `start`.
- `hi`, `lo`  out  WIDTH: architectural HI/LO.

## Operation
- States: IDLE, RUN, FINISH. `busy`=1 in RUN and FINISH.
- **IDLE + `start`**
  - Latch `op`, capture |a| and |b|, record result/remainder signs, clear the iteration counter, clear `div_zero`.
  - Signed ops take magnitudes; unsigned ops use operands as-is.
  - Divide with `b`=0: go directly to FINISH.
  - Otherwise go to RUN.
- **RUN**: one iteration per cycle for exactly `WIDTH` cycles, then FINISH.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring divide on a (WIDTH+1)-bit partial remainder.
- **FINISH**: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
  - Multiply: {hi,lo} = 2·WIDTH-bit product, negated if the operand signs differ.
  - Divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - Divide by zero: hi/lo unchanged, `div_zero`=1.
- **Most-negative / −1 divide**: lo = 2^(WIDTH−1) (wraps), hi = 0. No flag.
- **`start` while `busy`**: ignored; no queueing.
- **`hi_wr`/`lo_wr`**
  - Write `wdata` on the edge, only in IDLE and only when `start`=0.
  - `start` has priority; writes during `busy` are dropped.
  - Both strobes asserted together write both registers.
- **`reset` low**: immediate abort from any state, mid-operation included. State → IDLE; hi, lo, `busy`, `done`, `div_zero`, counter and accumulators → 0.

## Timing
- Call the accepting edge E0. `busy`=1 after E0.
- Normal operation:
  - Iterations occur on edges E1..E_WIDTH.
  - HI/LO are written on E_(WIDTH+1).
  - `done`=1 and `busy`=0 during the cycle after E_(WIDTH+1).
  - Total latency is WIDTH+1 cycles (33 for WIDTH=32).
- Divide by zero: `div_zero` and `done` are set on E1; `busy`=0 after E1.
- Back-to-back: a new `start` may be presented in the same cycle `done` is high; it is accepted.
- `hi`/`lo` are stable, with no partial values visible, except on the FINISH and MTHI/MTLO write edges.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mult_div_pkg` holds:
  - the `op` encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum;
  - a counter-width constant, $clog2(WIDTH+1).
- One sub-module, `md_step`: a combinational single-iteration datapath. It takes the op class, accumulator and partial remainder and returns their next values. The top level holds the FSM, counter, sign bookkeeping and HI/LO.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3) → after 33 cycles: `done` pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; `busy` high for exactly 33 cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, `div_zero`=0.
- DIVU a=100, b=0 with hi/lo preloaded to 0x11/0x22 via `hi_wr`/`lo_wr` → `done` one cycle after E0, `div_zero`=1, hi=0x11, lo=0x22. A following MULT clears `div_zero`.
- Abort and ignored requests:
  - Start MULT, pulse `reset` low at cycle 10 → all outputs 0 immediately.
  - A second `start` and an `hi_wr` presented during a later `busy` period → ignored; the result matches the first operation.
